// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer, optional parity bit.
// Parity generation is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] P_DATA,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       TX_OUT,
  output logic       Busy,
  output logic       Ready,
  output logic       Overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  state_t     state;
  state_t     next_state;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic [2:0] next_bit;
  logic       next_tx;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;
`else
  logic unused_par_inputs;
  assign unused_par_inputs = PAR_EN ^ PAR_TYP;
`endif

  // Ready comes from the registered count, so a same-cycle pop never frees a slot
  assign Ready      = (count < FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = Data_Valid && Ready;
  assign pop        = (next_state == START);
  assign next_bit   = bit_cnt + 3'd1;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= P_DATA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      Overflow <= Data_Valid && !Ready;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next_state = START;
        end
      end
      START: next_state = DATA;
      DATA: begin
        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          next_state = par_en_q ? PARITY : STOP;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: next_state = STOP;
`endif
      STOP:    next_state = fifo_empty ? IDLE : START;
      default: next_state = IDLE;
    endcase
  end

  // Line level is decoded from the upcoming state so TX_OUT is a plain flop
  always_comb begin
    next_tx = 1'b1;
    case (next_state)
      START: next_tx = 1'b0;
      DATA:  next_tx = (state == DATA) ? shift_reg[next_bit] : shift_reg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: next_tx = (^shift_reg) ^ par_typ_q;
`endif
      default: next_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      TX_OUT <= 1'b1;
      Busy   <= 1'b0;
    end else begin
      state  <= next_state;
      TX_OUT <= next_tx;
      Busy   <= (next_state != IDLE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      if (pop) begin
        shift_reg <= fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
`endif
      end
      if (state == DATA) begin
        bit_cnt <= next_bit;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx (FIFO_DEPTH=4); expectations
// follow UART_TX_PARITY_EN so the same bench serves both builds.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;
  logic       Ready;
  logic       Overflow;

  int errors = 0;
  int checks = 0;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .Ready      (Ready),
    .Overflow   (Overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic dv,
                               input logic pen, input logic ptyp);
    P_DATA     = data;
    Data_Valid = dv;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
  endtask

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Walks one frame from cycle index 'first', checking the line and Busy each cycle
  task automatic checkFrame(input string name, input logic [7:0] data,
                            input logic par_on, input logic par_bit, input int first);
    int   len = par_on ? 11 : 10;
    logic e;
    for (int i = first; i < len; i++) begin
      if (i == 0)                  e = 1'b0;
      else if (i <= 8)             e = data[i-1];
      else if (par_on && i == 9)   e = par_bit;
      else                         e = 1'b1;
      checkOutput($sformatf("%s tx[%0d]", name, i), TX_OUT, e);
      checkOutput($sformatf("%s busy[%0d]", name, i), Busy, 1'b1);
      tick();
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, " idle tx"}, TX_OUT, 1'b1);
    checkOutput({name, " idle busy"}, Busy, 1'b0);
  endtask

  logic exp_ready [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic exp_ovf   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rst tx", TX_OUT, 1'b1);
    checkOutput("rst busy", Busy, 1'b0);
    checkOutput("rst ovf", Overflow, 1'b0);
    checkOutput("rst ready", Ready, 1'b1);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIdle($sformatf("post-rst %0d", i));
    end

    // 0xA5 without parity: 10-cycle frame, start one cycle after the idle edge
    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("a5 pre-start tx", TX_OUT, 1'b1);
    checkOutput("a5 ready", Ready, 1'b1);
    tick();
    checkFrame("a5", 8'hA5, 1'b0, 1'b0, 0);
    checkIdle("a5");

    // 0xA5 even parity requested
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    checkFrame("a5 even", 8'hA5, PAR_BUILT, 1'b0, 0);
    checkIdle("a5 even");

    // 0xA5 odd parity, settings flipped after the frame starts
    applyStimulus(8'hA5, 1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkFrame("a5 odd", 8'hA5, PAR_BUILT, 1'b1, 0);
    checkIdle("a5 odd");

    // 0x3C odd parity requested
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    checkFrame("3c", 8'h3C, PAR_BUILT, 1'b1, 0);
    checkIdle("3c");

    // Back-to-back 0x01 then 0x80: Busy must stay high across both frames
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h80, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkFrame("b2b 01", 8'h01, 1'b0, 1'b0, 0);
    checkFrame("b2b 80", 8'h80, 1'b0, 1'b0, 0);
    checkIdle("b2b");

    // Six writes 0x10..0x15: FIFO fills after the fifth, sixth is dropped
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("ovf ready[%0d]", i), Ready, exp_ready[i]);
      checkOutput($sformatf("ovf pulse[%0d]", i), Overflow, exp_ovf[i]);
    end
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("q10 tx[4]", TX_OUT, 1'b0);
    tick();
    checkOutput("ovf pulse end", Overflow, 1'b0);
    checkOutput("ovf still full", Ready, 1'b0);
    checkFrame("q10", 8'h10, 1'b0, 1'b0, 5);
    checkFrame("q11", 8'h11, 1'b0, 1'b0, 0);
    checkFrame("q12", 8'h12, 1'b0, 1'b0, 0);
    checkFrame("q13", 8'h13, 1'b0, 1'b0, 0);
    checkFrame("q14", 8'h14, 1'b0, 1'b0, 0);
    checkIdle("queue drained");
    checkOutput("queue ready", Ready, 1'b1);

    // Reset during data bit 3 of 0xFF with two bytes queued
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("ff bit3 tx", TX_OUT, 1'b1);
    checkOutput("ff bit3 busy", Busy, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("abort tx", TX_OUT, 1'b1);
    checkOutput("abort busy", Busy, 1'b0);
    checkOutput("abort ready", Ready, 1'b1);
    checkOutput("abort ovf", Overflow, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      checkIdle($sformatf("after abort %0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
